// File: rtl/chargen_src_pkg.sv
// Shared constants for the character generator: strobe polarities, line terminators,
// default ring bounds and the state encoding.
package chargen_src_pkg;

    localparam logic N_T = 1'b0;
    localparam logic N_F = 1'b1;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int         LINE_LEN_DEF = 72;
    localparam logic [7:0] FIRST_CH_DEF = 8'h20;
    localparam logic [7:0] LAST_CH_DEF  = 8'h7E;

    typedef enum logic [1:0] {
        S_CHAR = 2'd0,
        S_CR   = 2'd1,
        S_LF   = 2'd2
    } state_t;

endpackage

// File: rtl/chargen_src_if.sv
// Byte write port between the generator (master) and the FIFO (slave), active-low strobes.
interface chargen_src_if;
    logic       n_wr;
    logic [7:0] port_out;
    logic       n_full;

    modport master (output n_wr, output port_out, input n_full);
    modport slave  (input n_wr, input port_out, output n_full);
endinterface

// File: rtl/chargen_ring.sv
// Wrapping printable-character incrementer: LAST_CH rolls over to FIRST_CH.
module chargen_ring #(
    parameter logic [7:0] FIRST_CH = 8'h20,
    parameter logic [7:0] LAST_CH  = 8'h7E
) (
    input  logic [7:0] x,
    output logic [7:0] y
);

    // successor of x within the printable ring
    always_comb begin
        if (x == LAST_CH) begin
            y = FIRST_CH;
        end else begin
            y = x + 8'd1;
        end
    end

endmodule

// File: rtl/chargen_src.sv
// Character generator feeding a byte FIFO: rotating printable lines ending in CR LF,
// advancing only on accepted writes so FIFO back-pressure never drops or repeats a byte.
module chargen_src
    import chargen_src_pkg::*;
#(
    parameter int         LINE_LEN = LINE_LEN_DEF,
    parameter logic [7:0] FIRST_CH = FIRST_CH_DEF,
    parameter logic [7:0] LAST_CH  = LAST_CH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               n_en,
    chargen_src_if.master      wr_bus,
    output logic [15:0]        line_cnt
);

    localparam int              COL_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [COL_W-1:0] col_r;
    logic [7:0]       start_r;
    logic [7:0]       cur_r;
    logic [15:0]      line_cnt_r;
    logic [7:0]       cur_inc_s;
    logic [7:0]       start_inc_s;
    logic             accept_s;

    chargen_ring #(.FIRST_CH(FIRST_CH), .LAST_CH(LAST_CH)) u_ring_cur (
        .x (cur_r),
        .y (cur_inc_s)
    );

    chargen_ring #(.FIRST_CH(FIRST_CH), .LAST_CH(LAST_CH)) u_ring_start (
        .x (start_r),
        .y (start_inc_s)
    );

    // a byte is taken whenever out of reset, enabled and the FIFO has room
    always_comb begin
        accept_s = ~rst & (n_en == N_T) & (wr_bus.n_full == N_F);
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_CHAR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state logic; holds unless the current byte was accepted
    always_comb begin
        state_nxt_s = state_r;
        if (accept_s) begin
            case (state_r)
                S_CHAR:  state_nxt_s = (col_r == COL_LAST) ? S_CR : S_CHAR;
                S_CR:    state_nxt_s = S_LF;
                S_LF:    state_nxt_s = S_CHAR;
                default: state_nxt_s = S_CHAR;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // output decode: byte on the port is always valid, even while stalled
    always_comb begin
        wr_bus.port_out = cur_r;
        wr_bus.n_wr     = accept_s ? N_T : N_F;
        case (state_r)
            S_CHAR:  wr_bus.port_out = cur_r;
            S_CR:    wr_bus.port_out = ASCII_CR;
            S_LF:    wr_bus.port_out = ASCII_LF;
            default: wr_bus.port_out = cur_r;
        endcase
    end

    // column, character and line counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r      <= '0;
            start_r    <= FIRST_CH;
            cur_r      <= FIRST_CH;
            line_cnt_r <= 16'd0;
        end else if (accept_s) begin
            case (state_r)
                S_CHAR: begin
                    if (col_r != COL_LAST) begin
                        col_r <= col_r + {{(COL_W-1){1'b0}}, 1'b1};
                        cur_r <= cur_inc_s;
                    end else begin
                        col_r <= col_r;
                    end
                end
                S_CR: begin
                    col_r <= col_r;
                end
                S_LF: begin
                    // next line starts one character further round the ring
                    col_r      <= '0;
                    start_r    <= start_inc_s;
                    cur_r      <= start_inc_s;
                    line_cnt_r <= line_cnt_r + 16'd1;
                end
                default: begin
                    col_r <= '0;
                    cur_r <= start_r;
                end
            endcase
        end else begin
            col_r <= col_r;
        end
    end

    assign line_cnt = line_cnt_r;

endmodule
